// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: transfer geometry and the
// per-cycle grant decision encoding.
package mem_pkg;

    localparam int MEM_XFER_BYTES = 8;
    localparam int DWORD_LSB      = 3;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating count of consecutive load grants taken while a store waits.
module starve_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment, increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single datamem port between loads and committed stores;
// grants are combinational, load responses return one cycle after grant.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int TAG_W      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [63:0]      ld_addr,
    input  logic [TAG_W-1:0] ld_tag,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [63:0]      st_addr,
    input  logic [63:0]      st_data,
    input  logic             st_urgent,
    output logic             mem_read_enable,
    output logic             mem_write_enable,
    output logic [63:0]      mem_address,
    output logic [63:0]      mem_write_data,
    input  logic [63:0]      mem_read_data,
    output logic             resp_valid,
    output logic [TAG_W-1:0] resp_tag,
    output logic [63:0]      resp_data
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    mem_op_e          op_s;
    logic             same_dw_s;
    logic             starve_sat_s;
    logic             cnt_inc_s;
    logic             cnt_clr_s;
    logic             resp_valid_q;
    logic             resp_valid_d;
    logic [TAG_W-1:0] resp_tag_q;
    logic [TAG_W-1:0] resp_tag_d;

    assign same_dw_s = (ld_addr[63:DWORD_LSB] == st_addr[63:DWORD_LSB]);

    // Grant decision; a store to the load's doubleword must land first.
    always_comb begin
        op_s = MEM_IDLE;
        if (!reset_n) begin
            op_s = MEM_IDLE;
        end else if (ld_valid && !st_valid) begin
            op_s = MEM_LOAD;
        end else if (st_valid && !ld_valid) begin
            op_s = MEM_STORE;
        end else if (ld_valid && st_valid) begin
            if (same_dw_s || st_urgent || starve_sat_s) begin
                op_s = MEM_STORE;
            end else begin
                op_s = MEM_LOAD;
            end
        end else begin
            op_s = MEM_IDLE;
        end
    end

    // Handshake and memory-port drive for the granted operation.
    always_comb begin
        ld_ready         = 1'b0;
        st_ready         = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = 64'd0;
        mem_write_data   = 64'd0;
        case (op_s)
            MEM_LOAD: begin
                ld_ready        = 1'b1;
                mem_read_enable = 1'b1;
                mem_address     = ld_addr;
            end
            MEM_STORE: begin
                st_ready         = 1'b1;
                mem_write_enable = 1'b1;
                mem_address      = st_addr;
                mem_write_data   = st_data;
            end
            default: begin
                ld_ready         = 1'b0;
                st_ready         = 1'b0;
                mem_read_enable  = 1'b0;
                mem_write_enable = 1'b0;
                mem_address      = 64'd0;
                mem_write_data   = 64'd0;
            end
        endcase
    end

    assign cnt_inc_s = (op_s == MEM_LOAD) && st_valid;
    assign cnt_clr_s = (op_s == MEM_STORE) || !st_valid;

    starve_counter #(
        .MAX (STARVE_MAX),
        .W   (CNT_W)
    ) u_starve (
        .clk   (clk),
        .rst_n (reset_n),
        .inc_i (cnt_inc_s),
        .clr_i (cnt_clr_s),
        .sat_o (starve_sat_s)
    );

    // Pending-response capture; the tag holds until the next load grant.
    always_comb begin
        resp_valid_d = (op_s == MEM_LOAD);
        if (op_s == MEM_LOAD) begin
            resp_tag_d = ld_tag;
        end else begin
            resp_tag_d = resp_tag_q;
        end
    end

    // Response register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_tag   = resp_tag_q;
    assign resp_data  = mem_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small datamem model that
// commits writes before later reads.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ld_valid;
    logic        ld_ready;
    logic [63:0] ld_addr;
    logic [3:0]  ld_tag;
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        st_urgent;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;
    logic        resp_valid;
    logic [3:0]  resp_tag;
    logic [63:0] resp_data;

    logic [63:0] mem_model [0:255];
    int          n_checks = 0;
    int          n_fail   = 0;

    mem_port_arbiter #(.TAG_W(4), .STARVE_MAX(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ld_valid         (ld_valid),
        .ld_ready         (ld_ready),
        .ld_addr          (ld_addr),
        .ld_tag           (ld_tag),
        .st_valid         (st_valid),
        .st_ready         (st_ready),
        .st_addr          (st_addr),
        .st_data          (st_data),
        .st_urgent        (st_urgent),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .resp_valid       (resp_valid),
        .resp_tag         (resp_tag),
        .resp_data        (resp_data)
    );

    always #5 clk = ~clk;

    // Datamem model, preloaded while reset is low; 0x40 holds 0xDEAD.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) begin
                mem_model[i] <= 64'hC0DE_0000_0000_0000 | 64'(i);
            end
            mem_model[8]  <= 64'h0000_0000_0000_DEAD;
            mem_read_data <= 64'd0;
        end else begin
            if (mem_write_enable) mem_model[mem_address[10:3]] <= mem_write_data;
            if (mem_read_enable)  mem_read_data <= mem_model[mem_address[10:3]];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic l, input logic s, input logic [63:0] a);
        check({tag, "_ld_ready"}, 64'(ld_ready), 64'(l));
        check({tag, "_st_ready"}, 64'(st_ready), 64'(s));
        check({tag, "_re"}, 64'(mem_read_enable), 64'(l));
        check({tag, "_we"}, 64'(mem_write_enable), 64'(s));
        check({tag, "_addr"}, mem_address, a);
    endtask

    initial begin
        reset_n = 1'b0; ld_valid = 1'b1; st_valid = 1'b1; st_urgent = 1'b0;
        ld_addr = 64'h40; ld_tag = 4'd0; st_addr = 64'h80; st_data = 64'd0;
        tick(); tick();
        #1;
        chk_grant("rst_forced", 1'b0, 1'b0, 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_tag", 64'(resp_tag), 64'd0);
        check("rst_cnt", 64'(dut.u_starve.cnt_q), 64'd0);
        ld_valid = 1'b0; st_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk_grant("idle", 1'b0, 1'b0, 64'd0);
        check("idle_wdata", mem_write_data, 64'd0);
        tick();

        // Load only.
        ld_valid = 1'b1; ld_addr = 64'h40; ld_tag = 4'd3;
        #1;
        chk_grant("ld_only", 1'b1, 1'b0, 64'h40);
        tick();
        ld_valid = 1'b0;
        #1;
        check("ld_only_rv", 64'(resp_valid), 64'd1);
        check("ld_only_tag", 64'(resp_tag), 64'd3);
        check("ld_only_data", resp_data, 64'hDEAD);
        tick();
        check("ld_only_rv_end", 64'(resp_valid), 64'd0);

        // Same doubleword: store first, then load sees the new data.
        ld_valid = 1'b1; ld_addr = 64'h48; ld_tag = 4'd5;
        st_valid = 1'b1; st_addr = 64'h4C; st_data = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk_grant("hazard_st", 1'b0, 1'b1, 64'h4C);
        check("hazard_wdata", mem_write_data, 64'h1234_5678_9ABC_DEF0);
        tick();
        st_valid = 1'b0;
        #1;
        check("hazard_no_resp", 64'(resp_valid), 64'd0);
        chk_grant("hazard_ld", 1'b1, 1'b0, 64'h48);
        tick();
        ld_valid = 1'b0;
        #1;
        check("hazard_rv", 64'(resp_valid), 64'd1);
        check("hazard_tag", 64'(resp_tag), 64'd5);
        check("hazard_data", resp_data, 64'h1234_5678_9ABC_DEF0);
        tick();

        // Starvation bound: four loads, then the waiting store.
        st_valid = 1'b1; st_addr = 64'h100; st_data = 64'hA5; ld_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ld_addr = 64'h200 + 64'(8 * i); ld_tag = 4'(i);
            #1;
            check("starve_cnt", 64'(dut.u_starve.cnt_q), 64'(i));
            chk_grant("starve_ld", 1'b1, 1'b0, ld_addr);
            tick();
        end
        ld_addr = 64'h220;
        #1;
        check("starve_sat", 64'(dut.u_starve.cnt_q), 64'd4);
        chk_grant("starve_st", 1'b0, 1'b1, 64'h100);
        tick();
        st_valid = 1'b0;
        #1;
        check("starve_clr", 64'(dut.u_starve.cnt_q), 64'd0);
        chk_grant("starve_ld_after", 1'b1, 1'b0, 64'h220);
        tick();
        ld_valid = 1'b0;
        tick();

        // Different doublewords, no urgency: load wins; then urgent store.
        ld_valid = 1'b1; ld_addr = 64'h300; st_valid = 1'b1; st_addr = 64'h380;
        #1;
        chk_grant("plain_both", 1'b1, 1'b0, 64'h300);
        tick();
        check("plain_cnt", 64'(dut.u_starve.cnt_q), 64'd1);
        st_urgent = 1'b1;
        #1;
        chk_grant("urgent", 1'b0, 1'b1, 64'h380);
        tick();
        check("urgent_cnt", 64'(dut.u_starve.cnt_q), 64'd0);
        st_valid = 1'b0; st_urgent = 1'b0; ld_valid = 1'b0;
        tick();

        // Back-to-back loads, tags 1..3 at 0x40, 0x48, 0x50.
        ld_valid = 1'b1; ld_addr = 64'h40; ld_tag = 4'd1;
        tick();
        ld_addr = 64'h48; ld_tag = 4'd2;
        #1;
        check("b2b_rv1", 64'(resp_valid), 64'd1);
        check("b2b_tag1", 64'(resp_tag), 64'd1);
        check("b2b_data1", resp_data, 64'hDEAD);
        tick();
        ld_addr = 64'h50; ld_tag = 4'd3;
        #1;
        check("b2b_rv2", 64'(resp_valid), 64'd1);
        check("b2b_tag2", 64'(resp_tag), 64'd2);
        check("b2b_data2", resp_data, 64'h1234_5678_9ABC_DEF0);
        tick();
        ld_valid = 1'b0;
        #1;
        check("b2b_rv3", 64'(resp_valid), 64'd1);
        check("b2b_tag3", 64'(resp_tag), 64'd3);
        check("b2b_data3", resp_data, 64'hC0DE_0000_0000_000A);
        tick();
        check("b2b_end", 64'(resp_valid), 64'd0);

        // Reset while a response is in flight drops it.
        ld_valid = 1'b1; ld_addr = 64'h40; ld_tag = 4'd7;
        tick();
        check("inflight_rv", 64'(resp_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_rv", 64'(resp_valid), 64'd0);
        check("midrst_tag", 64'(resp_tag), 64'd0);
        chk_grant("midrst_grant", 1'b0, 1'b0, 64'd0);
        ld_valid = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("post_rst_rv", 64'(resp_valid), 64'd0);
        tick();
        check("post_rst_rv2", 64'(resp_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
